spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter K_WIDTH, default 16, frame/word length in bits (>= 2).
REQ-002 SHALL have port i_clk  input  1  system clock; all logic synchronous to its rising edge.
REQ-003 SHALL have port i_rstn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_spi_clk  input  1  SPI clock from master, asynchronous to i_clk, idle low.
REQ-005 SHALL have port i_spi_csn  input  1  SPI chip select from master, active-low.
REQ-006 SHALL have port i_spi_mosi  input  1  SPI data from master.
REQ-007 SHALL have port o_spi_miso  output  1  SPI data to master.
REQ-008 SHALL have port o_spi_miso_oe  output  1  MISO output enable, high while selected.
REQ-009 SHALL have port i_tx_data  input  K_WIDTH  word to transmit.
REQ-010 SHALL have port i_tx_valid  input  1  i_tx_data valid.
REQ-011 SHALL have port o_tx_ready  output  1  TX holding register empty.
REQ-012 SHALL have port o_rx_data  output  K_WIDTH  last received word.
REQ-013 SHALL have port o_rx_valid  output  1  one-cycle pulse, o_rx_data updated.
REQ-014 SHALL have port o_tx_underrun  output  1  one-cycle pulse, frame started with empty holding register.
REQ-015 SHALL have port o_rx_abort  output  1  one-cycle pulse, csn deasserted mid-frame.

Function
REQ-016 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, both directions.
REQ-017 SHALL resynchronise i_spi_clk, i_spi_csn, i_spi_mosi through 2-flop synchronisers; edges detected by comparing sync output with a third registered copy; requires f(i_clk) >= 8 x f(spi_clk).
REQ-018 SHALL use FSM states IDLE, SHIFT: IDLE->SHIFT on detected csn falling edge; SHIFT->IDLE on detected csn rising edge.
REQ-019 SHALL, in SHIFT, sample synced mosi into RX shift register on each detected spi_clk rising edge; bit counter 0..K_WIDTH-1 increments per sample and wraps to 0 after K_WIDTH-1.
REQ-020 SHALL, on the K_WIDTH-th sample detected in cycle N, load o_rx_data with the complete word and pulse o_rx_valid in cycle N+1.
REQ-021 SHALL, on IDLE->SHIFT, move holding register to TX shift register and drive its MSB on o_spi_miso in the next cycle; o_tx_ready high the cycle after.
REQ-022 SHALL shift TX register left by one on each detected spi_clk falling edge, o_spi_miso = shift register MSB.
REQ-023 SHALL, for back-to-back frames (csn held low), reload TX shift register from holding register on the first falling edge after the K_WIDTH-th sample instead of shifting.
REQ-024 SHALL, at any TX load with holding register empty, load all zeros and pulse o_tx_underrun for one cycle.
REQ-025 SHALL capture i_tx_data into holding register when i_tx_valid and o_tx_ready are both high; o_tx_ready low while holding register full.
REQ-026 SHALL, if csn rising edge detected with bit counter != 0, discard partial RX word, keep o_rx_data unchanged, pulse o_rx_abort, reset bit counter.
REQ-027 SHALL ignore spi_clk edges and mosi while in IDLE; o_spi_miso = 0 and o_spi_miso_oe = 0 in IDLE.
REQ-028 SHALL, if TX load and holding-register capture coincide, load the old holding content and capture the new word (ready stays low).

Reset
REQ-029 SHALL on i_rstn low asynchronously force: FSM IDLE, counter 0, shift/holding registers 0, holding empty, o_tx_ready 1, o_rx_data 0, o_rx_valid/o_tx_underrun/o_rx_abort 0, o_spi_miso 0, o_spi_miso_oe 0, synchronisers to idle (clk 0, csn 1).
REQ-030 SHALL, on reset mid-frame, abandon the frame without o_rx_abort and resume in IDLE; frame in progress at release ignored until next csn falling edge.

Verification
REQ-031 Load 0xA55A, master sends 0x3C96 in one 16-bit frame -> master reads 0xA55A; o_rx_data=0x3C96, single o_rx_valid pulse.
REQ-032 No TX word loaded, frame 0xFFFF -> o_tx_underrun pulse at frame start, MISO all zeros, o_rx_data=0xFFFF.
REQ-033 csn held low, 2 frames 0x1234, 0x5678, TX words 0xAAAA then 0x5555 loaded in time -> two o_rx_valid pulses, master reads 0xAAAA, 0x5555.
REQ-034 csn deasserted after 7 bits -> o_rx_abort pulse, no o_rx_valid, o_rx_data unchanged; next full frame 0x0F0F received correctly.
REQ-035 i_rstn asserted after 9 bits -> outputs at reset values immediately; next frame 0xBEEF received correctly.
REQ-036 spi_clk toggled 16 times with csn high -> no o_rx_valid, o_spi_miso_oe stays 0.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: SPI mode 0 (CPOL=0, CPHA=0) slave, MSB first, full duplex.
// All SPI pins are resynchronised into i_clk. i_clk must run at least
// 8x faster than the SPI clock.
//
// Ports
//   i_clk, i_rstn             system clock, async active-low reset
//   i_spi_clk/csn/mosi        SPI pins from the master (asynchronous)
//   o_spi_miso, o_spi_miso_oe SPI data to the master and its output enable
//   i_tx_data/i_tx_valid      word for the TX holding register
//   o_tx_ready                holding register empty
//   o_rx_data/o_rx_valid      last complete received word, one-cycle strobe
//   o_tx_underrun             TX load found the holding register empty
//   o_rx_abort                csn released part-way through a word
//
// State | meaning
// ------+----------------------------------------------------------
// IDLE  | not selected; SPI clock and data ignored, MISO tri-stated
// SHIFT | selected; sample MOSI on SCLK rise, shift MISO on SCLK fall
module spi_slave #(
  parameter int K_WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_spi_clk,
  input  logic               i_spi_csn,
  input  logic               i_spi_mosi,
  output logic               o_spi_miso,
  output logic               o_spi_miso_oe,
  input  logic [K_WIDTH-1:0] i_tx_data,
  input  logic               i_tx_valid,
  output logic               o_tx_ready,
  output logic [K_WIDTH-1:0] o_rx_data,
  output logic               o_rx_valid,
  output logic               o_tx_underrun,
  output logic               o_rx_abort
);

  localparam int CNT_W = (K_WIDTH > 2) ? $clog2(K_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(K_WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t state, next_state;

  // [0],[1] form the synchroniser; [2] is the delayed copy for edge detect
  logic [2:0] sclk_s;
  logic [2:0] csn_s;
  logic [1:0] mosi_s;

  logic [1:0] settle_cnt;
  logic       armed;

  logic [K_WIDTH-1:0] tx_shift;
  logic [K_WIDTH-1:0] hold_reg;
  logic               hold_full;
  logic [K_WIDTH-1:0] rx_shift;
  logic [CNT_W-1:0]   bit_cnt;
  logic               reload_pend;

  logic sclk_rise, sclk_fall, csn_fall, csn_rise;
  logic start_frame, end_frame, samp, fall, reload, tx_load, tx_capture;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sclk_s <= 3'b000;
      csn_s  <= 3'b111;
      mosi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[1:0], i_spi_clk};
      csn_s  <= {csn_s[1:0], i_spi_csn};
      mosi_s <= {mosi_s[0], i_spi_mosi};
    end
  end

  assign sclk_rise =  sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] &  sclk_s[2];
  assign csn_rise  =  csn_s[1]  & ~csn_s[2];
  assign csn_fall  = ~csn_s[1]  &  csn_s[2];

  // The synchroniser resets to "deselected", so a csn held low across reset
  // release would look like a fresh falling edge. Only accept a falling edge
  // once the pipeline has refilled and csn has really been seen high.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      settle_cnt <= 2'd0;
      armed      <= 1'b0;
    end else begin
      if (settle_cnt != 2'd3)
        settle_cnt <= settle_cnt + 2'd1;
      if (settle_cnt == 2'd3 && csn_s[1])
        armed <= 1'b1;
    end
  end

  assign start_frame = (state == ST_IDLE) && csn_fall && armed;
  assign end_frame   = (state == ST_SHIFT) && csn_rise;
  assign samp        = (state == ST_SHIFT) && sclk_rise && !csn_rise;
  assign fall        = (state == ST_SHIFT) && sclk_fall && !csn_rise;
  assign reload      = fall && reload_pend;
  assign tx_load     = start_frame || reload;
  assign tx_capture  = i_tx_valid && !hold_full;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start_frame) next_state = ST_SHIFT;
      ST_SHIFT: if (csn_rise)    next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_spi_miso_oe = 1'b0;
    o_spi_miso    = 1'b0;
    if (state == ST_SHIFT) begin
      o_spi_miso_oe = 1'b1;
      o_spi_miso    = tx_shift[K_WIDTH-1];
    end
    o_tx_ready = ~hold_full;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tx_shift      <= '0;
      hold_reg      <= '0;
      hold_full     <= 1'b0;
      rx_shift      <= '0;
      bit_cnt       <= '0;
      reload_pend   <= 1'b0;
      o_rx_data     <= '0;
      o_rx_valid    <= 1'b0;
      o_tx_underrun <= 1'b0;
      o_rx_abort    <= 1'b0;
    end else begin
      o_rx_valid    <= 1'b0;
      o_tx_underrun <= 1'b0;
      o_rx_abort    <= 1'b0;

      // A load always takes the content present before this edge; an empty
      // holding register sends zeros.
      if (tx_load) begin
        tx_shift      <= hold_full ? hold_reg : '0;
        o_tx_underrun <= ~hold_full;
      end else if (fall) begin
        tx_shift <= {tx_shift[K_WIDTH-2:0], 1'b0};
      end

      if (tx_capture) begin
        hold_reg  <= i_tx_data;
        hold_full <= 1'b1;
      end else if (tx_load) begin
        hold_full <= 1'b0;
      end

      if (end_frame) begin
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
        rx_shift    <= '0;
        if (bit_cnt != '0)
          o_rx_abort <= 1'b1;
      end else if (samp) begin
        rx_shift <= {rx_shift[K_WIDTH-2:0], mosi_s[1]};
        if (bit_cnt == LAST_BIT) begin
          bit_cnt     <= '0;
          o_rx_data   <= {rx_shift[K_WIDTH-2:0], mosi_s[1]};
          o_rx_valid  <= 1'b1;
          reload_pend <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else if (reload) begin
        reload_pend <= 1'b0;
      end
    end
  end

endmodule
